if_stage: RTL and testbench

- Instruction-fetch stage with IF/ID pipeline register, directly upstream of the main control decoder.
- Holds the PC and issues one-outstanding fetches to instruction memory over a valid/ready request and a response-valid return.
- Registers the fetched word with its PC and exposes the pre-sliced opcode [6:0] that the control decoder consumes.
- Handles stalls from hazard logic and redirects from branch/jal/jalr resolution.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/if_id_reg.sv | 55 +++++
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: datapath width, bubble instruction, major opcodes
// and the instruction-fetch state encoding.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_S      = 7'b0100011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush > load > hold > bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN_P      = 32,
    parameter logic [31:0] NOP_INSTR_P = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              hold_i,
    input  logic [31:0]       instr_i,
    input  logic [XLEN_P-1:0] pc_i,
    output logic              valid_o,
    output logic [31:0]       instr_o,
    output logic [XLEN_P-1:0] pc_o,
    output logic [XLEN_P-1:0] pc4_o,
    output logic [6:0]        opcode_o
);

    logic              valid_q;
    logic [31:0]       instr_q;
    logic [XLEN_P-1:0] pc_q;
    logic [XLEN_P-1:0] pc4_q;

    // Pipeline register update: flush to a bubble, load a new word, hold on stall,
    // otherwise drain to a bubble while keeping the last PC fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR_P;
            pc_q    <= '0;
            pc4_q   <= XLEN_P'(4);
        end else if (flush_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR_P;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
            pc4_q   <= pc_i + XLEN_P'(4);
        end else if (!hold_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR_P;
        end
    end

    assign valid_o  = valid_q;
    assign instr_o  = instr_q;
    assign pc_o     = pc_q;
    assign pc4_o    = pc4_q;
    assign opcode_o = opcode_of(instr_q);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, one-outstanding imem fetch, IF/ID register.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module if_stage
#(
    parameter int unsigned         XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]     RESET_PC  = '0,
    parameter logic [31:0]         NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_id_valid,
    output logic [31:0]     if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic [6:0]      if_id_opcode
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    import riscv_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            drop_q, drop_d;
    logic [31:0]     hold_buf_q, hold_buf_d;
    logic            load;
    logic [31:0]     load_instr;

    // Fetch FSM next state. A redirect never loads IF/ID; a response that is
    // in flight when the redirect arrives is marked for discard via drop.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        hold_buf_d = hold_buf_q;
        load       = 1'b0;
        load_instr = imem_rsp_data;

        unique case (state_q)
            ST_FETCH: begin
                if (imem_req_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = ST_WAIT;
                    if (redirect_valid) drop_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = ST_FETCH;
                    if (drop_q || redirect_valid) begin
                        drop_d = 1'b0;
                    end else if (!stall) begin
                        load = 1'b1;
                    end else begin
                        hold_buf_d = imem_rsp_data;
                        state_d    = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    load       = 1'b1;
                    load_instr = hold_buf_q;
                    state_d    = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        if (redirect_valid) pc_d = redirect_pc & ~XLEN'(3);
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
            hold_buf_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            hold_buf_q <= hold_buf_d;
        end
    end

    assign imem_req_valid = (state_q == ST_FETCH) && !rst;
    assign imem_addr      = pc_q;

    if_id_reg #(
        .XLEN_P      (XLEN),
        .NOP_INSTR_P (NOP_INSTR)
    ) u_if_id (
        .clk_i    (clk),
        .rst_i    (rst),
        .flush_i  (redirect_valid),
        .load_i   (load),
        .hold_i   (stall),
        .instr_i  (load_instr),
        .pc_i     (req_pc_q),
        .valid_o  (if_id_valid),
        .instr_o  (if_id_instr),
        .pc_o     (if_id_pc),
        .pc4_o    (if_id_pc4),
        .opcode_o (if_id_opcode)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Saturating counters: delivered instructions and non-stalled empty cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (load && (fetch_cnt_q != '1))
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (!stall && !load && (bubble_cnt_q != '1))
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand corner sequences, and a
// randomized run against a queue-based reference model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] redirect_pc, imem_rsp_data;
    logic        imem_req_valid, if_id_valid;
    logic [31:0] imem_addr, if_id_instr, if_id_pc, if_id_pc4;
    logic [6:0]  if_id_opcode;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    if_stage #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_opcode   (if_id_opcode)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Full IF/ID output check against expected valid/instr/pc.
    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc);
        logic [31:0] i;
        i = ins;
        chk({tag, ".valid"},  if_id_valid,  v);
        chk({tag, ".instr"},  if_id_instr,  ins);
        chk({tag, ".pc"},     if_id_pc,     pc);
        chk({tag, ".pc4"},    if_id_pc4,    pc + 32'd4);
        chk({tag, ".opcode"}, if_id_opcode, i[6:0]);
    endtask

    task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rp,
                         input logic rdy, input logic rspv, input logic [31:0] rspd);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        imem_req_ready = rdy; imem_rsp_valid = rspv; imem_rsp_data = rspd;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        stall, redir;
        logic [31:0] rpc;
        logic        ready, rsp_v;
        logic [31:0] rsp_d;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr, e_pc;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic s, logic rv, logic [31:0] rp, logic rdy, logic rspv,
                                logic [31:0] rspd, logic er, logic [31:0] ea, logic ev,
                                logic [31:0] ei, logic [31:0] ep);
        vec_t t;
        t.stall = s; t.redir = rv; t.rpc = rp; t.ready = rdy; t.rsp_v = rspv; t.rsp_d = rspd;
        t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_instr = ei; t.e_pc = ep;
        return t;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic killed; } pend_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } held_t;

    pend_t       pend[$];
    held_t       held[$];
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
    logic        m_valid;
    int unsigned m_fetch, m_bubble;
    logic        mem_busy;
    int unsigned mem_cnt;

    function automatic logic model_req();
        return !rst && pend.size() == 0 && held.size() == 0;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic        ld;
        logic [31:0] ld_i, ld_p;
        pend_t       p;
        ld = 1'b0; ld_i = '0; ld_p = '0;
        if (rst) begin
            m_pc = 32'h0; pend.delete(); held.delete();
            m_valid = 1'b0; m_instr = NOP; m_ipc = 32'h0; m_ipc4 = 32'h4;
            m_fetch = 0; m_bubble = 0;
            return;
        end
        if (held.size() > 0) begin
            if (redirect_valid) held.delete();
            else if (!stall) begin
                ld = 1'b1; ld_i = held[0].instr; ld_p = held[0].pc; held.delete();
            end
        end else if (pend.size() > 0) begin
            if (imem_rsp_valid) begin
                p = pend.pop_front();
                if (!p.killed && !redirect_valid) begin
                    if (!stall) begin ld = 1'b1; ld_i = imem_rsp_data; ld_p = p.pc; end
                    else held.push_back('{instr: imem_rsp_data, pc: p.pc});
                end
            end else if (redirect_valid) pend[0].killed = 1'b1;
        end else if (imem_req_ready) begin
            pend.push_back('{pc: m_pc, killed: redirect_valid});
            m_pc = m_pc + 32'd4;
        end
        if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
        if (redirect_valid) begin
            m_valid = 1'b0; m_instr = NOP;
        end else if (ld) begin
            m_valid = 1'b1; m_instr = ld_i; m_ipc = ld_p; m_ipc4 = ld_p + 32'd4;
        end else if (!stall) begin
            m_valid = 1'b0; m_instr = NOP;
        end
        if (ld) m_fetch++;
        if (!stall && !ld) m_bubble++;
    endtask

    initial begin
        logic exp_req;

        vecs[0]  = mk(0,0,32'h0,  1,0,32'h0,        1,32'h000, 0,NOP,         32'h0);
        vecs[1]  = mk(0,0,32'h0,  1,1,32'h0000_0033,0,32'h004, 0,NOP,         32'h0);
        vecs[2]  = mk(0,0,32'h0,  1,0,32'h0,        1,32'h004, 1,32'h0000_0033,32'h0);
        vecs[3]  = mk(0,0,32'h0,  1,1,32'h0000_0033,0,32'h008, 0,NOP,         32'h0);
        vecs[4]  = mk(0,0,32'h0,  1,0,32'h0,        1,32'h008, 1,32'h0000_0033,32'h4);
        vecs[5]  = mk(1,0,32'h0,  1,1,32'h0000_0003,0,32'h00C, 0,NOP,         32'h4);
        vecs[6]  = mk(1,0,32'h0,  1,0,32'h0,        0,32'h00C, 0,NOP,         32'h4);
        vecs[7]  = mk(1,0,32'h0,  1,0,32'h0,        0,32'h00C, 0,NOP,         32'h4);
        vecs[8]  = mk(0,0,32'h0,  1,0,32'h0,        0,32'h00C, 0,NOP,         32'h4);
        vecs[9]  = mk(0,0,32'h0,  0,0,32'h0,        1,32'h00C, 1,32'h0000_0003,32'h8);
        vecs[10] = mk(0,0,32'h0,  1,0,32'h0,        1,32'h00C, 0,NOP,         32'h8);
        vecs[11] = mk(0,1,32'h103,0,0,32'h0,        0,32'h010, 0,NOP,         32'h8);
        vecs[12] = mk(0,0,32'h0,  0,1,32'h0000_0033,0,32'h100, 0,NOP,         32'h8);
        vecs[13] = mk(0,0,32'h0,  1,0,32'h0,        1,32'h100, 0,NOP,         32'h8);
        vecs[14] = mk(1,0,32'h0,  0,1,32'h0000_006F,0,32'h104, 0,NOP,         32'h8);
        vecs[15] = mk(1,1,32'h200,0,0,32'h0,        0,32'h104, 0,NOP,         32'h8);
        vecs[16] = mk(0,0,32'h0,  0,0,32'h0,        1,32'h200, 0,NOP,         32'h8);

        // Reset
        drive(1,0,0,32'h0,1,0,32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst.req_valid", imem_req_valid, 1'b0);
        chk_ifid("rst", 1'b0, NOP, 32'h0);

        // Directed table
        for (int i = 0; i < 17; i++) begin
            drive(0, vecs[i].stall, vecs[i].redir, vecs[i].rpc,
                  vecs[i].ready, vecs[i].rsp_v, vecs[i].rsp_d);
            #1;
            chk($sformatf("vec%0d.req_valid", i), imem_req_valid, vecs[i].e_req);
            chk($sformatf("vec%0d.addr", i), imem_addr, vecs[i].e_addr);
            chk_ifid($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc);
            @(posedge clk); #1;
        end

        // PC wrap: redirect to top word, accept, check next address wraps to 0
        drive(0,0,1,32'hFFFF_FFFE,0,0,32'h0);
        @(posedge clk); #1;
        drive(0,0,0,32'h0,1,0,32'h0);
        #1;
        chk("wrap.addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("wrap.req_valid", imem_req_valid, 1'b1);
        @(posedge clk); #1;
        drive(0,0,0,32'h0,0,1,32'h0000_0063);
        #1;
        chk("wrap.addr_zero", imem_addr, 32'h0000_0000);
        @(posedge clk); #1;
        drive(0,0,0,32'h0,0,0,32'h0);
        #1;
        chk_ifid("wrap", 1'b1, 32'h0000_0063, 32'hFFFF_FFFC);

        // Reset with a request outstanding; the late response must be ignored
        drive(0,0,0,32'h0,1,0,32'h0);
        @(posedge clk); #1;
        drive(1,0,0,32'h0,0,0,32'h0);
        #1;
        chk("midrst.req_during_rst", imem_req_valid, 1'b0);
        @(posedge clk); #1;
        drive(0,0,0,32'h0,0,1,32'h0000_006F);
        #1;
        chk("midrst.req_after", imem_req_valid, 1'b1);
        chk("midrst.addr_after", imem_addr, 32'h0);
        @(posedge clk); #1;
        drive(0,0,0,32'h0,0,0,32'h0);
        #1;
        chk("midrst.still_fetch", imem_req_valid, 1'b1);
        chk_ifid("midrst", 1'b0, NOP, 32'h0);

        // Randomized run against the reference model
        mem_busy = 1'b0; mem_cnt = 0;
        drive(1,0,0,32'h0,0,0,32'h0);
        model_step();
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst            = ($urandom_range(199) == 0);
            stall          = ($urandom_range(3) == 0);
            redirect_valid = ($urandom_range(9) == 0);
            redirect_pc    = $urandom;
            imem_req_ready = ($urandom_range(3) != 0);
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    mem_busy = 1'b0;
                end
            end
            #1;
            exp_req = model_req();
            chk("rnd.req_valid", imem_req_valid, exp_req);
            chk("rnd.addr", imem_addr, m_pc);
            chk("rnd.valid", if_id_valid, m_valid);
            chk("rnd.instr", if_id_instr, m_instr);
            chk("rnd.pc", if_id_pc, m_ipc);
            chk("rnd.pc4", if_id_pc4, m_ipc4);
`ifdef IF_PERF_CNT_EN
            chk("rnd.perf_fetch", perf_fetch_cnt, m_fetch);
            chk("rnd.perf_bubble", perf_bubble_cnt, m_bubble);
`endif
            @(posedge clk);
            if (exp_req && imem_req_ready) begin
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(3, 1);
            end
            if (rst) mem_busy = 1'b0;
            model_step();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
